// File: rtl/ir_conv_sequencer.sv
// IR convolution sequencer: streams an impulse response into the IR buffer, then sweeps tap index pairs per audio tick.
// Optional IR_LOAD_CKSUM_EN macro enables a running checksum of loaded samples on ir_checksum_out.
module ir_conv_sequencer #(
    parameter int MEMORY_DEPTH = 6000,
    parameter int IR_LENGTH    = 24000,
    parameter int RAM_LATENCY  = 2
) (
    input  logic               audio_clk,
    input  logic               rst_n_in,
    input  logic               load_start_in,
    input  logic signed [15:0] ir_sample_in,
    input  logic               ir_sample_valid_in,
    output logic               ir_sample_ready_out,
    input  logic               sample_tick_in,
    output logic [15:0]        ir_sample_index,
    output logic signed [15:0] write_data,
    output logic               write_enable,
    output logic               ir_data_in_valid,
    output logic [12:0]        first_ir_index,
    output logic [12:0]        second_ir_index,
    output logic               tap_valid_out,
    output logic               tap_last_out,
    output logic [12:0]        tap_offset_out,
    output logic               busy_out,
    output logic               load_done_out,
    output logic               overrun_out,
    output logic [31:0]        ir_checksum_out
);
    localparam logic [12:0] HALF     = 13'(MEMORY_DEPTH / 2);
    localparam logic [12:0] K_LAST   = 13'(MEMORY_DEPTH / 2 - 1);
    localparam logic [15:0] CNT_LAST = 16'(IR_LENGTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, READY, SWEEP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] count;
    logic [12:0] k;
    logic        pending;
    logic        beat;
    logic        sweep_end;
    logic        load_take;
    logic        drain_nxt;

    logic [RAM_LATENCY-1:0] vld_p;
    logic [RAM_LATENCY-1:0] last_p;
    logic [12:0]            ofs_p [RAM_LATENCY];

    // ready is registered in step with state, so a beat is only possible in LOAD
    assign beat      = ir_sample_valid_in && ir_sample_ready_out;
    assign sweep_end = (state == SWEEP) && (k == K_LAST);
    assign load_take = ((state == IDLE || state == READY) && load_start_in)
                     || (sweep_end && (pending || load_start_in));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load_start_in) state_nxt = LOAD;
            LOAD:    if (beat && count == CNT_LAST) state_nxt = READY;
            READY:   if (load_start_in) state_nxt = LOAD;
                     else if (sample_tick_in) state_nxt = SWEEP;
            SWEEP:   if (sweep_end) state_nxt = (pending || load_start_in) ? LOAD : READY;
            default: state_nxt = IDLE;
        endcase
    end

    // Tap pipeline stays occupied next cycle if a new pair enters or an inner stage holds one
    always_comb begin
        drain_nxt = (state == SWEEP);
        for (int i = 0; i < RAM_LATENCY - 1; i++) drain_nxt = drain_nxt | vld_p[i];
    end

    always_ff @(posedge audio_clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state               <= IDLE;
            count               <= '0;
            k                   <= '0;
            pending             <= 1'b0;
            ir_sample_ready_out <= 1'b0;
            ir_sample_index     <= '0;
            write_data          <= '0;
            write_enable        <= 1'b0;
            ir_data_in_valid    <= 1'b0;
            first_ir_index      <= '0;
            second_ir_index     <= '0;
            busy_out            <= 1'b0;
            load_done_out       <= 1'b0;
            overrun_out         <= 1'b0;
        end else begin
            state               <= state_nxt;
            ir_sample_ready_out <= (state_nxt == LOAD);
            busy_out            <= (state_nxt == LOAD) || (state_nxt == SWEEP) || drain_nxt;
            write_enable        <= beat;
            ir_data_in_valid    <= beat;
            load_done_out       <= beat && (count == CNT_LAST);

            if (beat) begin
                ir_sample_index <= count;
                write_data      <= ir_sample_in;
                count           <= count + 16'd1;
            end

            if (load_take) begin
                count       <= '0;
                pending     <= 1'b0;
                overrun_out <= 1'b0;
            end else if (state == SWEEP) begin
                if (load_start_in)  pending     <= 1'b1;
                if (sample_tick_in) overrun_out <= 1'b1;
            end

            if (state == READY && state_nxt == SWEEP) begin
                k               <= '0;
                first_ir_index  <= '0;
                second_ir_index <= HALF;
            end else if (state == SWEEP && !sweep_end) begin
                k               <= k + 13'd1;
                first_ir_index  <= k + 13'd1;
                second_ir_index <= k + 13'd1 + HALF;
            end else begin
                k               <= '0;
                first_ir_index  <= '0;
                second_ir_index <= '0;
            end
        end
    end

    // Tap pipeline: mirrors the IR buffer read latency so tap_* lines up with returned data
    always_ff @(posedge audio_clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vld_p  <= '0;
            last_p <= '0;
            for (int i = 0; i < RAM_LATENCY; i++) ofs_p[i] <= '0;
        end else begin
            vld_p[0]  <= (state == SWEEP);
            last_p[0] <= sweep_end;
            ofs_p[0]  <= (state == SWEEP) ? k : 13'd0;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                vld_p[i]  <= vld_p[i-1];
                last_p[i] <= last_p[i-1];
                ofs_p[i]  <= ofs_p[i-1];
            end
        end
    end

    assign tap_valid_out  = vld_p[RAM_LATENCY-1];
    assign tap_last_out   = last_p[RAM_LATENCY-1];
    assign tap_offset_out = ofs_p[RAM_LATENCY-1];

`ifdef IR_LOAD_CKSUM_EN
    function automatic logic [31:0] sext32(input logic signed [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    logic [31:0] cksum;

    always_ff @(posedge audio_clk or negedge rst_n_in) begin
        if (!rst_n_in)     cksum <= '0;
        else if (load_take) cksum <= '0;
        else if (beat)      cksum <= cksum + sext32(ir_sample_in);
    end

    assign ir_checksum_out = cksum;
`else
    assign ir_checksum_out = 32'd0;
`endif

endmodule

// File: tb/tb_ir_conv_sequencer.sv
// Self-checking bench for ir_conv_sequencer: randomized loads and sweeps against a timeline model.
module tb_ir_conv_sequencer;
    localparam int MEMORY_DEPTH = 6000;
    localparam int IR_LENGTH    = 24000;
    localparam int LAT          = 2;
    localparam int HALF         = MEMORY_DEPTH / 2;

    logic               audio_clk = 1'b0;
    logic               rst_n_in;
    logic               load_start_in;
    logic signed [15:0] ir_sample_in;
    logic               ir_sample_valid_in;
    logic               ir_sample_ready_out;
    logic               sample_tick_in;
    logic [15:0]        ir_sample_index;
    logic signed [15:0] write_data;
    logic               write_enable;
    logic               ir_data_in_valid;
    logic [12:0]        first_ir_index;
    logic [12:0]        second_ir_index;
    logic               tap_valid_out;
    logic               tap_last_out;
    logic [12:0]        tap_offset_out;
    logic               busy_out;
    logic               load_done_out;
    logic               overrun_out;
    logic [31:0]        ir_checksum_out;

    int checks   = 0;
    int failures = 0;

    ir_conv_sequencer #(
        .MEMORY_DEPTH(MEMORY_DEPTH),
        .IR_LENGTH   (IR_LENGTH),
        .RAM_LATENCY (LAT)
    ) dut (
        .audio_clk          (audio_clk),
        .rst_n_in           (rst_n_in),
        .load_start_in      (load_start_in),
        .ir_sample_in       (ir_sample_in),
        .ir_sample_valid_in (ir_sample_valid_in),
        .ir_sample_ready_out(ir_sample_ready_out),
        .sample_tick_in     (sample_tick_in),
        .ir_sample_index    (ir_sample_index),
        .write_data         (write_data),
        .write_enable       (write_enable),
        .ir_data_in_valid   (ir_data_in_valid),
        .first_ir_index     (first_ir_index),
        .second_ir_index    (second_ir_index),
        .tap_valid_out      (tap_valid_out),
        .tap_last_out       (tap_last_out),
        .tap_offset_out     (tap_offset_out),
        .busy_out           (busy_out),
        .load_done_out      (load_done_out),
        .overrun_out        (overrun_out),
        .ir_checksum_out    (ir_checksum_out)
    );

    always #5 audio_clk = ~audio_clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached (checks=%0d)", checks);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge audio_clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        #23;
        checks++;
        if ({ir_sample_ready_out, write_enable, ir_data_in_valid, tap_valid_out, tap_last_out,
             busy_out, load_done_out, overrun_out} !== 8'd0 || ir_sample_index !== 16'd0 ||
            write_data !== 16'sd0 || first_ir_index !== 13'd0 || second_ir_index !== 13'd0 ||
            tap_offset_out !== 13'd0 || ir_checksum_out !== 32'd0) begin
            failures++;
            $display("FAIL reset_state: ready=%b we=%b busy=%b idx=%0d first=%0d cksum=%h, all required 0",
                     ir_sample_ready_out, write_enable, busy_out, ir_sample_index, first_ir_index, ir_checksum_out);
        end
        @(negedge audio_clk);
        rst_n_in = 1'b1;
        sample_tick_in = 1'b1;
        step();
        sample_tick_in = 1'b0;
        checks++;
        if (busy_out !== 1'b0 || ir_sample_ready_out !== 1'b0 || first_ir_index !== 13'd0) begin
            failures++;
            $display("FAIL idle_tick_ignored: busy=%b ready=%b first=%0d, required 0/0/0",
                     busy_out, ir_sample_ready_out, first_ir_index);
        end
    endtask

    // valid_mode: 0 always, 1 toggling, 2 random; data_mode: 0 index, 1 random, 2 all -1
    task automatic load_ir(input bit issue_start, input bit tick_with_start, input int data_mode,
                           input int valid_mode, input int stop_after);
        int                 cnt = 0;
        int                 iter = 0;
        logic [31:0]        sum = 32'd0;
        logic [31:0]        exp_ck = 32'd0;
        bit                 v;
        bit                 exp_done;
        bit                 exp_live;
        logic signed [15:0] d;
        if (issue_start) begin
            load_start_in  = 1'b1;
            sample_tick_in = tick_with_start;
            step();
            load_start_in  = 1'b0;
            sample_tick_in = 1'b0;
            checks++;
            if (ir_sample_ready_out !== 1'b1 || busy_out !== 1'b1 || overrun_out !== 1'b0 ||
                first_ir_index !== 13'd0 || write_enable !== 1'b0 || ir_checksum_out !== 32'd0) begin
                failures++;
                $display("FAIL load_entry: ready=%b busy=%b ovr=%b first=%0d we=%b cksum=%h, required 1/1/0/0/0/0",
                         ir_sample_ready_out, busy_out, overrun_out, first_ir_index, write_enable, ir_checksum_out);
            end
        end
        while (cnt < IR_LENGTH && (stop_after < 0 || iter < stop_after)) begin
            case (valid_mode)
                0:       v = 1'b1;
                1:       v = (iter % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            case (data_mode)
                0:       d = 16'(cnt);
                1:       d = 16'($urandom);
                default: d = -16'sd1;
            endcase
            ir_sample_valid_in = v;
            ir_sample_in       = d;
            load_start_in      = ($urandom_range(0, 49) == 0);
            sample_tick_in     = ($urandom_range(0, 7) == 0);
            step();
            iter++;
            checks++;
            if (write_enable !== v || ir_data_in_valid !== v) begin
                failures++;
                $display("FAIL load_we iter=%0d: we=%b dv=%b, required %b", iter, write_enable, ir_data_in_valid, v);
            end
            if (v) begin
                checks++;
                if (ir_sample_index !== 16'(cnt) || write_data !== d) begin
                    failures++;
                    $display("FAIL load_write: idx=%0d data=%0d, required idx=%0d data=%0d",
                             ir_sample_index, write_data, cnt, d);
                end
                cnt++;
                sum = sum + {{16{d[15]}}, d};
            end
            exp_done = v && (cnt == IR_LENGTH);
            exp_live = (cnt < IR_LENGTH);
            checks++;
            if (load_done_out !== exp_done || ir_sample_ready_out !== exp_live || busy_out !== exp_live) begin
                failures++;
                $display("FAIL load_status cnt=%0d: done=%b ready=%b busy=%b, required %b/%b/%b",
                         cnt, load_done_out, ir_sample_ready_out, busy_out, exp_done, exp_live, exp_live);
            end
`ifdef IR_LOAD_CKSUM_EN
            exp_ck = sum;
`endif
            checks++;
            if (ir_checksum_out !== exp_ck || overrun_out !== 1'b0 || tap_valid_out !== 1'b0 ||
                first_ir_index !== 13'd0) begin
                failures++;
                $display("FAIL load_side cnt=%0d: cksum=%h ovr=%b tap=%b first=%0d, required %h/0/0/0",
                         cnt, ir_checksum_out, overrun_out, tap_valid_out, first_ir_index, exp_ck);
            end
        end
        ir_sample_valid_in = 1'b0;
        load_start_in      = 1'b0;
        sample_tick_in     = 1'b0;
        if (cnt == IR_LENGTH) begin
            step();
            checks++;
            if (ir_sample_ready_out !== 1'b0 || write_enable !== 1'b0 || load_done_out !== 1'b0 ||
                busy_out !== 1'b0 || ir_checksum_out !== exp_ck) begin
                failures++;
                $display("FAIL ready_state: ready=%b we=%b done=%b busy=%b cksum=%h, required 0/0/0/0/%h",
                         ir_sample_ready_out, write_enable, load_done_out, busy_out, ir_checksum_out, exp_ck);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        ir_sample_valid_in = 1'b1;
        ir_sample_in       = 16'sh1234;
        step();
        checks++;
        if (write_enable !== 1'b1) begin
            failures++;
            $display("FAIL midload_beat: we=%b, required 1", write_enable);
        end
        #2 rst_n_in = 1'b0;
        #1;
        checks++;
        if ({ir_sample_ready_out, write_enable, ir_data_in_valid, tap_valid_out, busy_out,
             load_done_out, overrun_out} !== 7'd0 || ir_sample_index !== 16'd0 || write_data !== 16'sd0 ||
            first_ir_index !== 13'd0 || second_ir_index !== 13'd0 || ir_checksum_out !== 32'd0) begin
            failures++;
            $display("FAIL async_reset: ready=%b we=%b busy=%b idx=%0d data=%0d cksum=%h, all required 0",
                     ir_sample_ready_out, write_enable, busy_out, ir_sample_index, write_data, ir_checksum_out);
        end
        repeat (2) @(posedge audio_clk);
        #2 rst_n_in = 1'b1;
        sample_tick_in = 1'b1;
        repeat (4) begin
            step();
            checks++;
            if (ir_sample_ready_out !== 1'b0 || write_enable !== 1'b0 || busy_out !== 1'b0 ||
                load_done_out !== 1'b0 || first_ir_index !== 13'd0 || tap_valid_out !== 1'b0) begin
                failures++;
                $display("FAIL post_reset_idle: ready=%b we=%b busy=%b done=%b first=%0d tap=%b, required 0",
                         ir_sample_ready_out, write_enable, busy_out, load_done_out, first_ir_index, tap_valid_out);
            end
        end
        ir_sample_valid_in = 1'b0;
        sample_tick_in     = 1'b0;
    endtask

    // Sweep starting from READY; extra tick / load request land on the edge numbered by sweep cycle
    task automatic run_sweep(input int extra_tick_at, input int load_at, input bit ovr_start);
        bit ovr   = ovr_start;
        bit pend  = 1'b0;
        int lasts = 0;
        bit tv;
        bit tl;
        bit eb;
        bit er;
        int ef;
        int es;
        sample_tick_in = 1'b1;
        for (int j = 0; j <= HALF + LAT; j++) begin
            step();
            sample_tick_in = (j + 1 == extra_tick_at);
            load_start_in  = (j + 1 == load_at);
            if (j == extra_tick_at) ovr = 1'b1;
            if (j == load_at) pend = 1'b1;
            if (pend && j >= HALF) ovr = 1'b0;
            ef = (j < HALF) ? j : 0;
            es = (j < HALF) ? j + HALF : 0;
            tv = (j >= LAT) && (j < HALF + LAT);
            tl = tv && (j - LAT == HALF - 1);
            er = pend && (j >= HALF);
            eb = er || (j <= HALF + LAT - 1);
            if (tap_last_out === 1'b1) lasts++;
            checks++;
            if (first_ir_index !== 13'(ef) || second_ir_index !== 13'(es)) begin
                failures++;
                $display("FAIL sweep_index j=%0d: (%0d,%0d), required (%0d,%0d)",
                         j, first_ir_index, second_ir_index, ef, es);
            end
            checks++;
            if (tap_valid_out !== tv || tap_last_out !== tl) begin
                failures++;
                $display("FAIL sweep_tap j=%0d: valid=%b last=%b, required %b/%b", j, tap_valid_out, tap_last_out, tv, tl);
            end
            if (tv) begin
                checks++;
                if (tap_offset_out !== 13'(j - LAT)) begin
                    failures++;
                    $display("FAIL sweep_offset j=%0d: %0d, required %0d", j, tap_offset_out, j - LAT);
                end
            end
            checks++;
            if (busy_out !== eb || ir_sample_ready_out !== er || overrun_out !== ovr || write_enable !== 1'b0) begin
                failures++;
                $display("FAIL sweep_status j=%0d: busy=%b ready=%b ovr=%b we=%b, required %b/%b/%b/0",
                         j, busy_out, ir_sample_ready_out, overrun_out, write_enable, eb, er, ovr);
            end
        end
        sample_tick_in = 1'b0;
        load_start_in  = 1'b0;
        checks++;
        if (lasts !== 1) begin
            failures++;
            $display("FAIL sweep_last_count: %0d, required 1", lasts);
        end
    endtask

    task automatic test_load_toggle();
        load_ir(1'b1, 1'b0, 1, 1, 400);
        test_reset_mid_load();
    endtask

    task automatic test_full_load();
        load_ir(1'b1, 1'b0, 0, 0, -1);
    endtask

    task automatic test_sweep_basic();
        run_sweep(-1, -1, 1'b0);
    endtask

    task automatic test_simultaneous();
        load_ir(1'b1, 1'b1, 2, 0, -1);
        checks++;
`ifdef IR_LOAD_CKSUM_EN
        if (ir_checksum_out !== 32'hFFFFA240) begin
            failures++;
            $display("FAIL cksum_minus_one: %h, required FFFFA240", ir_checksum_out);
        end
`else
        if (ir_checksum_out !== 32'd0) begin
            failures++;
            $display("FAIL cksum_disabled: %h, required 0", ir_checksum_out);
        end
`endif
    endtask

    task automatic test_overrun();
        run_sweep(100, -1, 1'b0);
    endtask

    task automatic test_pending_load();
        run_sweep(-1, 500, 1'b1);
        load_ir(1'b0, 1'b0, 1, 2, 300);
        test_reset_mid_load();
    endtask

    initial begin
        rst_n_in           = 1'b0;
        load_start_in      = 1'b0;
        ir_sample_in       = 16'sd0;
        ir_sample_valid_in = 1'b0;
        sample_tick_in     = 1'b0;
        test_reset();
        test_load_toggle();
        test_full_load();
        test_sweep_basic();
        test_simultaneous();
        test_overrun();
        test_pending_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
